// File: rtl/clk_div_sched_pkg.sv
// Shared constants for the programmable clock divider.
// Default ratios: /2, /10, /100 expressed as half-periods.
package clk_div_sched_pkg;

  localparam int CNT_W_DEF = 8;

  localparam logic [CNT_W_DEF-1:0] HALF_DIV2   = 8'd0;
  localparam logic [CNT_W_DEF-1:0] HALF_DIV10  = 8'd4;
  localparam logic [CNT_W_DEF-1:0] HALF_DIV100 = 8'd49;

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: counter, output flop, active ratio/enable, pending slot.
// Ports: clk_i, rst_i, def_half_i, wr_i/wr_half_i/wr_en_i, clk_o, pend_o, done_o.
module clk_div_chan
  import clk_div_sched_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [CNT_W-1:0] def_half_i,
  input  logic             wr_i,
  input  logic [CNT_W-1:0] wr_half_i,
  input  logic             wr_en_i,
  output logic             clk_o,
  output logic             pend_o,
  output logic             done_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] half_q, half_d;
  logic             en_q, en_d;
  logic             clk_q, clk_d;
  logic             pend_q, pend_d;
  logic [CNT_W-1:0] phalf_q, phalf_d;
  logic             pen_q, pen_d;
  logic             done_q, done_d;
  logic             at_end;
  logic             apply;

  // Falling toggle that closes a full period; disabled channels
  // have no period to finish so they take the update at once.
  assign at_end = (cnt_q == half_q) && clk_q;
  assign apply  = pend_q && (!en_q || at_end);

  always_comb begin
    cnt_d   = cnt_q;
    half_d  = half_q;
    en_d    = en_q;
    clk_d   = clk_q;
    pend_d  = pend_q;
    phalf_d = phalf_q;
    pen_d   = pen_q;
    done_d  = apply;
    if (apply) begin
      half_d = phalf_q;
      en_d   = pen_q;
      cnt_d  = '0;
      clk_d  = 1'b0;
      pend_d = 1'b0;
    end else if (en_q) begin
      if (cnt_q == half_q) begin
        clk_d = ~clk_q;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else begin
      clk_d = 1'b0;
      cnt_d = '0;
    end
    // wr_i only arrives when the slot is empty, so it never
    // collides with an apply in the same cycle.
    if (wr_i) begin
      pend_d  = 1'b1;
      phalf_d = wr_half_i;
      pen_d   = wr_en_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q   <= '0;
      half_q  <= def_half_i;
      en_q    <= 1'b1;
      clk_q   <= 1'b0;
      pend_q  <= 1'b0;
      phalf_q <= '0;
      pen_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      half_q  <= half_d;
      en_q    <= en_d;
      clk_q   <= clk_d;
      pend_q  <= pend_d;
      phalf_q <= phalf_d;
      pen_q   <= pen_d;
      done_q  <= done_d;
    end
  end

  assign clk_o  = clk_q;
  assign pend_o = pend_q;
  assign done_o = done_q;

endmodule

// File: rtl/clk_div_sched.sv
// Multi-channel glitch-free programmable divider with shared config port.
// Ports: CLK_in, RST, cfg_* request/ready/err, CLK_out, pending, upd_done.
module clk_div_sched
  import clk_div_sched_pkg::*;
#(
  parameter int NUM_CH = 3,
  parameter int CNT_W  = CNT_W_DEF,
  parameter int CH_W   = 3,
  parameter logic [NUM_CH*CNT_W-1:0] DEF_HALF =
    {HALF_DIV100, HALF_DIV10, HALF_DIV2}
) (
  input  logic              CLK_in,
  input  logic              RST,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_half,
  input  logic              cfg_en,
  output logic              cfg_err,
  output logic [NUM_CH-1:0] CLK_out,
  output logic [NUM_CH-1:0] pending,
  output logic [NUM_CH-1:0] upd_done
);

  logic [NUM_CH-1:0] sel;
  logic              oor;
  logic              rdy;
  logic              acc;
  logic              err_q, err_d;

  // Decode by matching each channel index; anything left
  // unmatched is out of range and always accepted.
  always_comb begin
    sel = '0;
    oor = 1'b1;
    rdy = 1'b1;
    for (int i = 0; i < NUM_CH; i++) begin
      if (cfg_ch == CH_W'(i)) begin
        sel[i] = 1'b1;
        oor    = 1'b0;
        rdy    = ~pending[i];
      end
    end
  end

  assign cfg_ready = rdy;
  assign acc       = cfg_valid && rdy;
  assign err_d     = acc && oor;

  always_ff @(posedge CLK_in) begin
    if (RST) err_q <= 1'b0;
    else     err_q <= err_d;
  end

  assign cfg_err = err_q;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    clk_div_chan #(
      .CNT_W(CNT_W)
    ) u_ch (
      .clk_i     (CLK_in),
      .rst_i     (RST),
      .def_half_i(DEF_HALF[g*CNT_W +: CNT_W]),
      .wr_i      (acc && sel[g]),
      .wr_half_i (cfg_half),
      .wr_en_i   (cfg_en),
      .clk_o     (CLK_out[g]),
      .pend_o    (pending[g]),
      .done_o    (upd_done[g])
    );
  end

endmodule
